// File: rtl/rv32_ctrl_pkg.sv
// Shared definitions for the RV32 multi-cycle control path.
//   state_t       : sequencer states (encoding is visible on the debug state port)
//   OP_*          : RV32 base opcodes the sequencer understands
//   IMM_*         : ImmSel encodings for the immediate generator
//   WB_*          : WBSel encodings for the write-back mux
//   opcode_legal  : true for opcodes the datapath can execute
//   branch_taken  : evaluates a branch condition from funct3 and comparator flags
package rv32_ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    localparam logic [1:0] WB_MEM = 2'd0;
    localparam logic [1:0] WB_ALU = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;

    function automatic logic opcode_legal(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_LUI: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // BrLT already carries the signed/unsigned choice made through BrUn,
    // so blt/bltu and bge/bgeu share the same condition.
    function automatic logic branch_taken(input logic [2:0] f3,
                                          input logic       eq,
                                          input logic       lt);
        case (f3)
            3'b000:         return eq;
            3'b001:         return !eq;
            3'b100, 3'b110: return lt;
            3'b101, 3'b111: return !lt;
            default:        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait watchdog.
// Counts consecutive cycles in which a memory request is stalled (requested
// but not ready). timeout is raised combinationally during the stalled cycle
// that completes MEM_TIMEOUT consecutive stalls, so the sequencer can move to
// TRAP on that clock edge.
// Ports:
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   stall   : mem_req high and mem_ready low this cycle
//   timeout : this cycle is the MEM_TIMEOUT-th consecutive stall
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic stall,
    output logic timeout
);

    localparam logic [CNT_W-1:0] LAST_STALL = CNT_W'(MEM_TIMEOUT - 1);

    logic [CNT_W-1:0] count_reg;

    // Any non-stalled cycle (ready seen, or no request outstanding because the
    // sequencer left FETCH/MEM) restarts the count.
    always_ff @(posedge clk) begin
        if (rst || !stall) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign timeout = stall && (count_reg == LAST_STALL);

endmodule

// File: rtl/rv32_multicycle_sequencer.sv
// Multi-cycle control FSM for the RV32 datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, shares one memory
// port between instruction fetch and load/store with a req/ready handshake,
// and traps on illegal opcodes, unsupported branch funct3 or memory timeout.
// Ports:
//   clk, rst                 : clock and synchronous active-high reset
//   opcode/funct3/funct7_in  : instruction fields from IR
//   BrEq, BrLT               : branch comparator results
//   mem_ready                : memory completed the current access
//   mem_req/mem_we/mem_ifetch: memory request, write, address-from-PC
//   IRWrite, PCWrite, PCSel  : IR/PC update controls
//   RegWEn, Asel, Bsel       : register write enable and ALU operand selects
//   ImmSel, ALUSel, funct7   : immediate format, ALU op and sub/sra qualifier
//   BrUn                     : unsigned branch compare
//   WBSel                    : write-back source
//   trap                     : sticky fault flag
//   state                    : current FSM state (debug)
module rv32_multicycle_sequencer
    import rv32_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_in,
    input  logic       BrEq,
    input  logic       BrLT,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_ifetch,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       PCSel,
    output logic       RegWEn,
    output logic       Asel,
    output logic       Bsel,
    output logic [2:0] ImmSel,
    output logic [2:0] ALUSel,
    output logic       funct7,
    output logic       BrUn,
    output logic [1:0] WBSel,
    output logic       trap,
    output logic [2:0] state
);

    state_t state_reg;
    state_t state_next;
    logic   mem_stall;
    logic   mem_timeout;

    // Derived from the state register rather than from mem_req so the
    // watchdog does not form a combinational loop through the output logic.
    assign mem_stall = !rst && !mem_ready &&
                       ((state_reg == FETCH) || (state_reg == MEM));

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_mem_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .stall   (mem_stall),
        .timeout (mem_timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    assign state = state_reg;

    always_comb begin
        state_next = state_reg;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_ifetch = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        PCSel      = 1'b0;
        RegWEn     = 1'b0;
        Asel       = 1'b0;
        Bsel       = 1'b0;
        ImmSel     = IMM_I;
        ALUSel     = 3'd0;
        funct7     = 1'b0;
        BrUn       = 1'b0;
        WBSel      = WB_ALU;
        trap       = 1'b0;

        // During reset every output keeps its idle default, so an access
        // in flight is dropped without a write or PC update.
        if (rst) begin
            state_next = FETCH;
        end else begin
            case (state_reg)
                FETCH: begin
                    mem_req    = 1'b1;
                    mem_ifetch = 1'b1;
                    if (mem_ready) begin
                        IRWrite    = 1'b1;
                        state_next = DECODE;
                    end else if (mem_timeout) begin
                        state_next = TRAP;
                    end
                end

                DECODE: begin
                    state_next = opcode_legal(opcode) ? EXEC : TRAP;
                end

                EXEC: begin
                    case (opcode)
                        OP_R: begin
                            ALUSel     = funct3;
                            funct7     = funct7_in;
                            state_next = WB;
                        end
                        OP_I: begin
                            // Immediate operand for the ALU's second input.
                            ALUSel     = funct3;
                            funct7     = funct7_in;
                            Bsel       = 1'b1;
                            state_next = WB;
                        end
                        OP_LOAD: begin
                            Bsel       = 1'b1;
                            ImmSel     = IMM_I;
                            state_next = MEM;
                        end
                        OP_STORE: begin
                            Bsel       = 1'b1;
                            ImmSel     = IMM_S;
                            state_next = MEM;
                        end
                        OP_BRANCH: begin
                            Asel   = 1'b1;
                            Bsel   = 1'b1;
                            ImmSel = IMM_B;
                            BrUn   = funct3[1];
                            // funct3 010/011 are not branch encodings.
                            if (funct3[2:1] == 2'b01) begin
                                state_next = TRAP;
                            end else begin
                                PCWrite    = 1'b1;
                                PCSel      = branch_taken(funct3, BrEq, BrLT);
                                state_next = FETCH;
                            end
                        end
                        OP_JAL, OP_LUI: begin
                            state_next = WB;
                        end
                        default: begin
                            state_next = TRAP;
                        end
                    endcase
                end

                MEM: begin
                    // Address selects stay asserted for the whole wait so the
                    // ALU keeps presenting the same address.
                    mem_req = 1'b1;
                    mem_we  = (opcode == OP_STORE);
                    Bsel    = 1'b1;
                    ImmSel  = (opcode == OP_STORE) ? IMM_S : IMM_I;
                    if (mem_ready) begin
                        if (opcode == OP_STORE) begin
                            PCWrite    = 1'b1;
                            state_next = FETCH;
                        end else begin
                            state_next = WB;
                        end
                    end else if (mem_timeout) begin
                        state_next = TRAP;
                    end
                end

                WB: begin
                    RegWEn     = 1'b1;
                    PCWrite    = 1'b1;
                    state_next = FETCH;
                    case (opcode)
                        OP_R: begin
                            ALUSel = funct3;
                            funct7 = funct7_in;
                        end
                        OP_I: begin
                            ALUSel = funct3;
                            funct7 = funct7_in;
                            Bsel   = 1'b1;
                        end
                        OP_LOAD: begin
                            WBSel = WB_MEM;
                        end
                        OP_JAL: begin
                            WBSel  = WB_PC4;
                            Asel   = 1'b1;
                            Bsel   = 1'b1;
                            ImmSel = IMM_J;
                            PCSel  = 1'b1;
                        end
                        OP_LUI: begin
                            WBSel  = WB_IMM;
                            ImmSel = IMM_U;
                        end
                        default: begin
                            RegWEn     = 1'b0;
                            PCWrite    = 1'b0;
                            state_next = TRAP;
                        end
                    endcase
                end

                TRAP: begin
                    trap = 1'b1;
                end

                default: begin
                    state_next = TRAP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_multicycle_sequencer.sv
// Directed testbench for rv32_multicycle_sequencer.
module tb_rv32_multicycle_sequencer;

    localparam logic [6:0] R_OP   = 7'b0110011;
    localparam logic [6:0] LD_OP  = 7'b0000011;
    localparam logic [6:0] ST_OP  = 7'b0100011;
    localparam logic [6:0] BR_OP  = 7'b1100011;
    localparam logic [6:0] JAL_OP = 7'b1101111;
    localparam logic [6:0] LUI_OP = 7'b0110111;
    localparam logic [6:0] BAD_OP = 7'b1111111;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_in;
    logic       BrEq;
    logic       BrLT;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       mem_ifetch;
    logic       IRWrite;
    logic       PCWrite;
    logic       PCSel;
    logic       RegWEn;
    logic       Asel;
    logic       Bsel;
    logic [2:0] ImmSel;
    logic [2:0] ALUSel;
    logic       funct7;
    logic       BrUn;
    logic [1:0] WBSel;
    logic       trap;
    logic [2:0] state;

    int vec_cnt = 0;
    int err_cnt = 0;

    rv32_multicycle_sequencer #(
        .MEM_TIMEOUT (16),
        .CNT_W       (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7_in  (funct7_in),
        .BrEq       (BrEq),
        .BrLT       (BrLT),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_ifetch (mem_ifetch),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .PCSel      (PCSel),
        .RegWEn     (RegWEn),
        .Asel       (Asel),
        .Bsel       (Bsel),
        .ImmSel     (ImmSel),
        .ALUSel     (ALUSel),
        .funct7     (funct7),
        .BrUn       (BrUn),
        .WBSel      (WBSel),
        .trap       (trap),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // FETCH with zero-wait memory, ends in DECODE.
    task automatic fetch_ok(input string tag);
        mem_ready = 1'b1;
        #1;
        check({tag, "_f_state"}, state, 0);
        check({tag, "_f_req"}, mem_req, 1);
        check({tag, "_f_ifetch"}, mem_ifetch, 1);
        check({tag, "_f_irw"}, IRWrite, 1);
        tick();
    endtask

    typedef struct packed {
        logic [2:0] f3;
        logic       eq;
        logic       lt;
        logic       sel;
        logic       un;
    } br_vec_t;

    br_vec_t br_tab [6];

    initial begin
        br_tab[0] = '{f3: 3'b000, eq: 1'b1, lt: 1'b0, sel: 1'b1, un: 1'b0}; // beq taken
        br_tab[1] = '{f3: 3'b001, eq: 1'b1, lt: 1'b0, sel: 1'b0, un: 1'b0}; // bne not taken
        br_tab[2] = '{f3: 3'b111, eq: 1'b0, lt: 1'b0, sel: 1'b1, un: 1'b1}; // bgeu taken
        br_tab[3] = '{f3: 3'b100, eq: 1'b0, lt: 1'b1, sel: 1'b1, un: 1'b0}; // blt taken
        br_tab[4] = '{f3: 3'b101, eq: 1'b0, lt: 1'b1, sel: 1'b0, un: 1'b0}; // bge not taken
        br_tab[5] = '{f3: 3'b110, eq: 1'b0, lt: 1'b0, sel: 1'b0, un: 1'b1}; // bltu not taken

        rst = 1'b1; opcode = 7'd0; funct3 = 3'd0; funct7_in = 1'b0;
        BrEq = 1'b0; BrLT = 1'b0; mem_ready = 1'b0;
        tick();
        tick();
        check("rst_state", state, 0);
        check("rst_req", mem_req, 0);
        check("rst_pcw", PCWrite, 0);
        check("rst_irw", IRWrite, 0);
        check("rst_trap", trap, 0);
        rst = 1'b0;
        $display("[%0t] reset done", $time);

        // add x3,x1,x2
        opcode = R_OP; funct3 = 3'b000; funct7_in = 1'b0;
        fetch_ok("add");
        check("add_dec_state", state, 1);
        check("add_dec_req", mem_req, 0);
        check("add_dec_irw", IRWrite, 0);
        tick();
        check("add_ex_state", state, 2);
        check("add_ex_alu", ALUSel, 0);
        check("add_ex_pcw", PCWrite, 0);
        check("add_ex_regw", RegWEn, 0);
        tick();
        check("add_wb_state", state, 4);
        check("add_wb_regw", RegWEn, 1);
        check("add_wb_pcw", PCWrite, 1);
        check("add_wb_pcsel", PCSel, 0);
        check("add_wb_wbsel", WBSel, 1);
        tick();
        check("add_done_state", state, 0);
        $display("[%0t] add x3,x1,x2 retired", $time);

        // sra: ALU op and qualifier pass through in EXEC
        opcode = R_OP; funct3 = 3'b101; funct7_in = 1'b1;
        fetch_ok("sra");
        tick();
        check("sra_ex_alu", ALUSel, 5);
        check("sra_ex_f7", funct7, 1);
        tick();
        tick();
        check("sra_done_state", state, 0);
        $display("[%0t] sra retired", $time);

        // lw: 15 stalled fetch cycles (one short of timeout), then 3 in MEM
        opcode = LD_OP; funct3 = 3'b010; funct7_in = 1'b0; mem_ready = 1'b0;
        #1;
        for (int i = 0; i < 15; i++) begin
            check("lw_fstall_state", state, 0);
            check("lw_fstall_irw", IRWrite, 0);
            tick();
        end
        fetch_ok("lw");
        mem_ready = 1'b0;
        tick();
        check("lw_ex_state", state, 2);
        check("lw_ex_bsel", Bsel, 1);
        check("lw_ex_imm", ImmSel, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("lw_mem_state", state, 3);
            check("lw_mem_req", mem_req, 1);
            check("lw_mem_ifetch", mem_ifetch, 0);
            check("lw_mem_we", mem_we, 0);
            check("lw_mem_bsel", Bsel, 1);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        check("lw_mem_rdy_req", mem_req, 1);
        check("lw_mem_rdy_pcw", PCWrite, 0);
        tick();
        check("lw_wb_state", state, 4);
        check("lw_wb_wbsel", WBSel, 0);
        check("lw_wb_regw", RegWEn, 1);
        check("lw_wb_pcw", PCWrite, 1);
        check("lw_wb_pcsel", PCSel, 0);
        tick();
        check("lw_done_state", state, 0);
        $display("[%0t] lw with stalls retired", $time);

        // branches
        opcode = BR_OP;
        for (int k = 0; k < 6; k++) begin
            funct3 = br_tab[k].f3; BrEq = br_tab[k].eq; BrLT = br_tab[k].lt;
            fetch_ok("br");
            tick();
            check("br_ex_state", state, 2);
            check("br_ex_pcw", PCWrite, 1);
            check("br_ex_pcsel", PCSel, br_tab[k].sel);
            check("br_ex_brun", BrUn, br_tab[k].un);
            check("br_ex_asel", Asel, 1);
            check("br_ex_imm", ImmSel, 2);
            tick();
            check("br_done_state", state, 0);
            $display("[%0t] branch funct3=%0d eq=%0d lt=%0d retired", $time,
                     br_tab[k].f3, br_tab[k].eq, br_tab[k].lt);
        end
        BrEq = 1'b0; BrLT = 1'b0;

        // jal
        opcode = JAL_OP; funct3 = 3'b000;
        fetch_ok("jal");
        tick();
        check("jal_ex_pcw", PCWrite, 0);
        tick();
        check("jal_wb_wbsel", WBSel, 2);
        check("jal_wb_imm", ImmSel, 3);
        check("jal_wb_pcsel", PCSel, 1);
        check("jal_wb_asel", Asel, 1);
        check("jal_wb_regw", RegWEn, 1);
        tick();
        $display("[%0t] jal retired", $time);

        // lui
        opcode = LUI_OP;
        fetch_ok("lui");
        tick();
        tick();
        check("lui_wb_wbsel", WBSel, 3);
        check("lui_wb_imm", ImmSel, 4);
        check("lui_wb_pcsel", PCSel, 0);
        check("lui_wb_pcw", PCWrite, 1);
        tick();
        $display("[%0t] lui retired", $time);

        // sw, zero wait
        opcode = ST_OP; funct3 = 3'b010;
        fetch_ok("sw");
        tick();
        check("sw_ex_imm", ImmSel, 1);
        check("sw_ex_bsel", Bsel, 1);
        tick();
        check("sw_mem_state", state, 3);
        check("sw_mem_we", mem_we, 1);
        check("sw_mem_pcw", PCWrite, 1);
        check("sw_mem_pcsel", PCSel, 0);
        check("sw_mem_regw", RegWEn, 0);
        tick();
        check("sw_done_state", state, 0);
        $display("[%0t] sw retired", $time);

        // sw abandoned by reset while MEM waits
        fetch_ok("swr");
        mem_ready = 1'b0;
        tick();
        tick();
        check("swr_mem_state", state, 3);
        check("swr_mem_we", mem_we, 1);
        check("swr_mem_pcw", PCWrite, 0);
        rst = 1'b1;
        #1;
        check("swr_rst_req", mem_req, 0);
        check("swr_rst_we", mem_we, 0);
        check("swr_rst_pcw", PCWrite, 0);
        tick();
        rst = 1'b0;
        #1;
        check("swr_after_state", state, 0);
        check("swr_after_we", mem_we, 0);
        check("swr_after_pcw", PCWrite, 0);
        $display("[%0t] sw abandoned by reset", $time);

        // illegal opcode
        opcode = BAD_OP; funct3 = 3'b000;
        fetch_ok("bad");
        check("bad_dec_state", state, 1);
        tick();
        check("bad_trap_state", state, 5);
        for (int i = 0; i < 20; i++) begin
            check("bad_trap_flag", trap, 1);
            check("bad_trap_req", mem_req, 0);
            check("bad_trap_pcw", PCWrite, 0);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("bad_rst_state", state, 0);
        check("bad_rst_trap", trap, 0);
        $display("[%0t] illegal opcode trapped and cleared", $time);

        // fetch watchdog
        opcode = R_OP; mem_ready = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) begin
            check("wd_stall_state", state, 0);
            check("wd_stall_req", mem_req, 1);
            tick();
        end
        check("wd_trap_state", state, 5);
        check("wd_trap_flag", trap, 1);
        check("wd_trap_req", mem_req, 0);
        tick();
        check("wd_trap_hold_req", mem_req, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        $display("[%0t] fetch watchdog trapped", $time);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
